mc_controlunit: RTL and testbench

Multicycle controller for the ARM-subset processor. It sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback states. Each instruction takes 3–5 cycles instead of one. It holds the NZCV status flags and the per-instruction condition result, and issues every datapath enable and mux select.

---
 rtl/mc_controlunit.sv | 228 ++++++++++++++++++++++
 tb/tb_mc_controlunit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_controlunit.sv
// Multicycle controller for the ARM-subset datapath: state sequencing, NZCV and condition gating.
// Optional MCCU_MEMREADY_EN: FETCH, MEMREAD and MEMWRITE wait for MemReady.
module mc_controlunit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instr,
    input  logic [3:0]  Flags,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] nzcv_q, nzcv_d;
    logic       condexr_q, condexr_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       mem_rdy;
    logic       unused_bits;

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign rd    = Instr[15:12];

`ifdef MCCU_MEMREADY_EN
    assign mem_rdy     = MemReady;
    assign unused_bits = ^{Instr[19:16], Instr[11:0]};
`else
    assign mem_rdy     = 1'b1;
    assign unused_bits = ^{Instr[19:16], Instr[11:0], MemReady};
`endif

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    logic next_pc, branch, reg_w, mem_w, alu_op;

    // Per-state datapath controls before condition gating
    always_comb begin
        next_pc   = 1'b0;
        branch    = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        alu_op    = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        case (state_q)
            S_FETCH: begin
                IRWrite   = mem_rdy;
                next_pc   = mem_rdy;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMREAD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECUTER: alu_op = 1'b1;
            S_EXECUTEI: begin
                alu_op  = 1'b1;
                ALUSrcB = 2'b01;
            end
            S_ALUWB:    reg_w = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    logic [1:0] flag_w;
    logic       no_write;

    // ALU operation and flag-write decode
    always_comb begin
        ALUControl = 3'b000;
        flag_w     = 2'b00;
        if (alu_op) begin
            case (funct[4:1])
                4'b0100: flag_w = funct[0] ? 2'b11 : 2'b00;
                4'b0010: begin
                    ALUControl = 3'b001;
                    flag_w     = funct[0] ? 2'b11 : 2'b00;
                end
                4'b0000: begin
                    ALUControl = 3'b010;
                    flag_w     = funct[0] ? 2'b10 : 2'b00;
                end
                4'b1100: begin
                    ALUControl = 3'b011;
                    flag_w     = funct[0] ? 2'b10 : 2'b00;
                end
                4'b0001: begin
                    ALUControl = 3'b100;
                    flag_w     = funct[0] ? 2'b10 : 2'b00;
                end
                4'b1010: begin
                    ALUControl = 3'b001;
                    flag_w     = 2'b11;
                end
                default: ;
            endcase
        end
    end

    // Compare must also suppress the ALUWB register write, where ALUOp is low
    assign no_write = (op == 2'b00) && (funct[4:1] == 4'b1010);

    logic n_f, z_f, c_f, v_f, cond_ex;
    assign {n_f, z_f, c_f, v_f} = nzcv_q;

    always_comb begin
        cond_ex = 1'b1;
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            default: cond_ex = 1'b1;
        endcase
    end

    always_comb begin
        condexr_d = condexr_q;
        nzcv_d    = nzcv_q;
        if (state_q == S_DECODE) condexr_d = cond_ex;
        if (((state_q == S_EXECUTER) || (state_q == S_EXECUTEI)) && condexr_q) begin
            if (flag_w[1]) nzcv_d[3:2] = Flags[3:2];
            if (flag_w[0]) nzcv_d[1:0] = Flags[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            nzcv_q    <= 4'b0000;
            condexr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nzcv_q    <= nzcv_d;
            condexr_q <= condexr_d;
        end
    end

    assign PCWrite  = next_pc | (condexr_q & (branch | (reg_w & (rd == 4'hF))));
    assign RegWrite = reg_w & condexr_q & ~no_write;
    assign MemWrite = mem_w & condexr_q;
    assign ImmSrc   = op;
    assign RegSrc   = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
    assign State    = 4'(state_q);

endmodule

// File: tb/tb_mc_controlunit.sv
// Directed bench for mc_controlunit: per-cycle control vectors against hand-computed values.
module tb_mc_controlunit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Instr;
    logic [3:0]  Flags;
    logic        MemReady;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  State;

    int ncmp = 0;
    int nerr = 0;

    mc_controlunit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Instr      (Instr),
        .Flags      (Flags),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .State      (State)
    );

    always #5 clk = ~clk;

    // {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
    function automatic logic [16:0] ev(input int st, input int pcw, input int irw, input int rw,
                                       input int mw, input int adr, input int res, input int sa,
                                       input int sb, input int alu);
        return {4'(st), 1'(pcw), 1'(irw), 1'(rw), 1'(mw), 1'(adr), 2'(res), 1'(sa), 2'(sb), 3'(alu)};
    endfunction

    task automatic chk_ctl(input string tag, input logic [16:0] exp);
        logic [16:0] obs;
        obs = {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl};
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s instr=%h observed=%b expected=%b", tag, Instr, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load an instruction, check FETCH and DECODE, leave the FSM in the state after DECODE
    task automatic fd(input logic [31:0] ins, input logic [3:0] fl);
        Instr = ins;
        Flags = fl;
        chk_ctl("fetch", ev(0, 1, 1, 0, 0, 0, 2, 1, 2, 0));
        step();
        chk_ctl("decode", ev(1, 0, 0, 0, 0, 0, 2, 1, 2, 0));
        step();
    endtask

    initial begin
        rst_n    = 1'b0;
        Instr    = 32'h0;
        Flags    = 4'h0;
        MemReady = 1'b1;
        #1;
        chk_ctl("rst_fetch", ev(0, 1, 1, 0, 0, 0, 2, 1, 2, 0));
        chk("rst_nzcv", dut.nzcv_q, 4'b0000);
        #11 rst_n = 1'b1;

        // ADD R1,R2,R3
        fd(32'hE0821003, 4'b0000);
        chk_ctl("add_exec", ev(6, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        chk_ctl("add_aluwb", ev(8, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        step();

        // LDR
        fd(32'hE5921004, 4'b0000);
        chk_ctl("ldr_memadr", ev(2, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        chk("ldr_immsrc", 4'(ImmSrc), 4'b0001);
        chk("ldr_regsrc", 4'(RegSrc), 4'b0000);
        step();
        chk_ctl("ldr_memread", ev(3, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        step();
        chk_ctl("ldr_memwb", ev(4, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        step();

        // STR
        fd(32'hE5821004, 4'b0000);
        chk_ctl("str_memadr", ev(2, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        chk("str_regsrc", 4'(RegSrc), 4'b0010);
        step();
        chk_ctl("str_memwrite", ev(5, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        step();

        // ADDS loads all four flags
        fd(32'hE0921003, 4'b0011);
        chk_ctl("adds_exec", ev(6, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        chk_ctl("adds_aluwb", ev(8, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        chk("adds_nzcv", dut.nzcv_q, 4'b0011);
        step();

        // ORRS immediate loads only N,Z
        fd(32'hE3911001, 4'b1100);
        chk_ctl("orrs_exec", ev(7, 0, 0, 0, 0, 0, 0, 0, 1, 3));
        step();
        chk("orrs_nzcv", dut.nzcv_q, 4'b1111);
        step();

        // EOR without S leaves flags alone
        fd(32'hE0221003, 4'b0000);
        chk_ctl("eor_exec", ev(6, 0, 0, 0, 0, 0, 0, 0, 0, 4));
        step();
        chk("eor_nzcv", dut.nzcv_q, 4'b1111);
        step();

        // CMP R0,#0 giving Z=1, then BEQ taken, ADDNE PC skipped
        fd(32'hE3500000, 4'b0100);
        chk_ctl("cmp_exec", ev(7, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        step();
        chk_ctl("cmp_aluwb", ev(8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("cmp_nzcv", dut.nzcv_q, 4'b0100);
        step();
        fd(32'h0A000001, 4'b0000);
        chk_ctl("beq_taken", ev(9, 1, 0, 0, 0, 0, 2, 0, 1, 0));
        chk("beq_regsrc", 4'(RegSrc), 4'b0001);
        step();
        fd(32'h1088F003, 4'b0000);
        chk_ctl("addne_exec", ev(6, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        chk_ctl("addne_skip", ev(8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();

        // CMP giving Z=0, then BEQ not taken, ADDNE PC writes PC
        fd(32'hE3500000, 4'b0000);
        step();
        chk("cmp2_nzcv", dut.nzcv_q, 4'b0000);
        step();
        fd(32'h0A000001, 4'b0100);
        chk_ctl("beq_not", ev(9, 0, 0, 0, 0, 0, 2, 0, 1, 0));
        step();
        fd(32'h1088F003, 4'b0000);
        step();
        chk_ctl("addne_pc", ev(8, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        step();

        // Op=11 returns to FETCH after DECODE
        fd(32'hEC000000, 4'b0000);
        chk_ctl("op11_back", ev(0, 1, 1, 0, 0, 0, 2, 1, 2, 0));

        // Set N,Z then reset in the middle of an ADDS EXECUTER
        fd(32'hE3911001, 4'b1100);
        step();
        step();
        chk("pre_rst_nzcv", dut.nzcv_q, 4'b1100);
        fd(32'hE0921003, 4'b0011);
        #2 rst_n = 1'b0;
        #1;
        chk_ctl("rst_mid", ev(0, 1, 1, 0, 0, 0, 2, 1, 2, 0));
        chk("rst_mid_nzcv", dut.nzcv_q, 4'b0000);
        #2 rst_n = 1'b1;
        fd(32'h0A000001, 4'b0000);
        chk_ctl("rst_beq_not", ev(9, 0, 0, 0, 0, 0, 2, 0, 1, 0));
        step();

`ifdef MCCU_MEMREADY_EN
        Instr    = 32'hE5821004;
        MemReady = 1'b0;
        chk_ctl("mr_hold0", ev(0, 0, 0, 0, 0, 0, 2, 1, 2, 0));
        step();
        chk_ctl("mr_hold1", ev(0, 0, 0, 0, 0, 0, 2, 1, 2, 0));
        step();
        chk_ctl("mr_hold2", ev(0, 0, 0, 0, 0, 0, 2, 1, 2, 0));
        MemReady = 1'b1;
        chk_ctl("mr_go", ev(0, 1, 1, 0, 0, 0, 2, 1, 2, 0));
        step();
        chk_ctl("mr_decode", ev(1, 0, 0, 0, 0, 0, 2, 1, 2, 0));
        step();
        step();
        MemReady = 1'b0;
        chk_ctl("mr_memw0", ev(5, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        step();
        chk_ctl("mr_memw1", ev(5, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        MemReady = 1'b1;
        step();
        chk_ctl("mr_done", ev(0, 1, 1, 0, 0, 0, 2, 1, 2, 0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
